data_path: RTL and testbench

- Register/bus/ALU datapath of the 8-bit computer, directly downstream of the control unit.
- Consumes the control unit's strobes (IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, ALU_Sel, Bus1_Sel, Bus2_Sel).
- Returns IR and CCR_Result to the control unit.
- Drives the memory system with address (MAR) and to_memory (Bus1), and takes from_memory back.

---
 rtl/data_path.sv | 144 ++++++++++++++
 tb/tb_data_path.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// data_path: register/bus/ALU datapath of the 8-bit computer, driven by the control unit's strobes.
// Define DATA_PATH_BUS_TRACE_EN to add the trace_bus2/trace_valid debug outputs.
module data_path #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  IR_Load,
   input  logic                  MAR_Load,
   input  logic                  PC_Load,
   input  logic                  PC_Inc,
   input  logic                  A_Load,
   input  logic                  B_Load,
   input  logic                  CCR_Load,
   input  logic [2:0]            ALU_Sel,
   input  logic [1:0]            Bus1_Sel,
   input  logic [1:0]            Bus2_Sel,
   input  logic [DATA_WIDTH-1:0] from_memory,
   output logic [DATA_WIDTH-1:0] IR,
   output logic [3:0]            CCR_Result,
   output logic [DATA_WIDTH-1:0] address,
`ifdef DATA_PATH_BUS_TRACE_EN
   output logic [DATA_WIDTH-1:0] to_memory,
   output logic [DATA_WIDTH-1:0] trace_bus2,
   output logic                  trace_valid
`else
   output logic [DATA_WIDTH-1:0] to_memory
`endif
);

   localparam int MSB = DATA_WIDTH - 1;
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] ir_q, ir_d, mar_q, mar_d, pc_q, pc_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]            ccr_q, ccr_d;

   logic [DATA_WIDTH-1:0] bus1, bus2, alu_result, op2;
   logic [DATA_WIDTH:0]   sum_ext;
   logic [3:0]            alu_flags;
   logic                  carry, ovf;

   always_comb begin
      case (Bus1_Sel)
         2'b00:   bus1 = pc_q;
         2'b01:   bus1 = a_q;
         2'b10:   bus1 = b_q;
         default: bus1 = '0;
      endcase
   end

   // In1 is always B, In2 is Bus1; INC/DEC reuse the add/sub path with a constant one.
   always_comb begin
      alu_result = '0;
      sum_ext    = '0;
      op2        = '0;
      carry      = 1'b0;
      ovf        = 1'b0;
      case (ALU_Sel)
         3'b000, 3'b100: begin
            op2        = ALU_Sel[2] ? ONE : bus1;
            sum_ext    = {1'b0, b_q} + {1'b0, op2};
            alu_result = sum_ext[MSB:0];
            carry      = sum_ext[DATA_WIDTH];
            ovf        = (b_q[MSB] == op2[MSB]) && (alu_result[MSB] != b_q[MSB]);
         end
         3'b001, 3'b101: begin
            op2        = ALU_Sel[2] ? ONE : bus1;
            sum_ext    = {1'b0, b_q} - {1'b0, op2};
            alu_result = sum_ext[MSB:0];
            carry      = sum_ext[DATA_WIDTH];
            ovf        = (b_q[MSB] != op2[MSB]) && (alu_result[MSB] != b_q[MSB]);
         end
         3'b010:  alu_result = b_q & bus1;
         3'b011:  alu_result = b_q | bus1;
         3'b110:  alu_result = b_q ^ bus1;
         default: alu_result = ~b_q;
      endcase
      alu_flags = {alu_result[MSB], (alu_result == '0), ovf, carry};
   end

   always_comb begin
      case (Bus2_Sel)
         2'b00:   bus2 = alu_result;
         2'b01:   bus2 = bus1;
         2'b10:   bus2 = from_memory;
         default: bus2 = '0;
      endcase
   end

   always_comb begin
      ir_d  = IR_Load  ? bus2 : ir_q;
      mar_d = MAR_Load ? bus2 : mar_q;
      a_d   = A_Load   ? bus2 : a_q;
      b_d   = B_Load   ? bus2 : b_q;
      ccr_d = CCR_Load ? alu_flags : ccr_q;
      if (PC_Load)
         pc_d = bus2;
      else if (PC_Inc)
         pc_d = pc_q + ONE;
      else
         pc_d = pc_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ir_q  <= '0;
         mar_q <= '0;
         pc_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         ccr_q <= '0;
      end else begin
         ir_q  <= ir_d;
         mar_q <= mar_d;
         pc_q  <= pc_d;
         a_q   <= a_d;
         b_q   <= b_d;
         ccr_q <= ccr_d;
      end
   end

`ifdef DATA_PATH_BUS_TRACE_EN
   logic trace_valid_q, trace_valid_d;

   assign trace_valid_d = IR_Load | MAR_Load | PC_Load | A_Load | B_Load;

   always_ff @(posedge Clk) begin
      if (Reset)
         trace_valid_q <= 1'b0;
      else
         trace_valid_q <= trace_valid_d;
   end

   assign trace_bus2  = Reset ? '0 : bus2;
   assign trace_valid = trace_valid_q;
`endif

   assign IR         = ir_q;
   assign CCR_Result = ccr_q;
   assign address    = mar_q;
   assign to_memory  = bus1;

endmodule

// File: tb/tb_data_path.sv
// Randomized self-checking bench for data_path against an arithmetic reference model.
module tb_data_path;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
   logic [2:0] ALU_Sel;
   logic [1:0] Bus1_Sel, Bus2_Sel;
   logic [7:0] from_memory;
   logic [7:0] IR, address, to_memory;
   logic [3:0] CCR_Result;

   data_path #(.DATA_WIDTH(8)) dut (
      .Clk(Clk), .Reset(Reset),
      .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
      .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load),
      .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
      .from_memory(from_memory),
      .IR(IR), .CCR_Result(CCR_Result), .address(address), .to_memory(to_memory)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] m_pc, m_a, m_b, m_ir, m_mar;
   logic [3:0] m_ccr;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%02h", tag, got);
      end
   endtask

   function automatic logic [7:0] ref_bus1();
      case (Bus1_Sel)
         2'd0:    return m_pc;
         2'd1:    return m_a;
         2'd2:    return m_b;
         default: return 8'h00;
      endcase
   endfunction

   // Flags from plain integer arithmetic: signed results outside -128..127 overflow.
   task automatic ref_alu(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op,
                          output logic [7:0] r, output logic [3:0] f);
      int ux, uy, sx, sy, full, sfull;
      bit c, v;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      full  = 0;
      sfull = 0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'd0: begin full = ux + uy; sfull = sx + sy; c = (full > 255); end
         3'd1: begin full = ux - uy; sfull = sx - sy; c = (ux < uy); end
         3'd2: full = ux & uy;
         3'd3: full = ux | uy;
         3'd4: begin full = ux + 1; sfull = sx + 1; c = (full > 255); end
         3'd5: begin full = ux - 1; sfull = sx - 1; c = (ux == 0); end
         3'd6: full = ux ^ uy;
         default: full = ~ux;
      endcase
      v = (sfull > 127) || (sfull < -128);
      r = full[7:0];
      f = {r[7], (r == 8'h00), v, c};
   endtask

   task automatic idle();
      IR_Load = 0; MAR_Load = 0; PC_Load = 0; PC_Inc = 0;
      A_Load = 0; B_Load = 0; CCR_Load = 0; Reset = 0;
   endtask

   task automatic set_in(input bit ir, input bit mar, input bit pcl, input bit pci, input bit al,
                         input bit bl, input bit ccr, input logic [2:0] alu, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [7:0] mem);
      IR_Load = ir; MAR_Load = mar; PC_Load = pcl; PC_Inc = pci;
      A_Load = al; B_Load = bl; CCR_Load = ccr;
      ALU_Sel = alu; Bus1_Sel = s1; Bus2_Sel = s2; from_memory = mem;
   endtask

   // One clock with the currently driven inputs; the model applies the same edge.
   task automatic step(input string tag);
      logic [7:0] b1, b2, r;
      logic [3:0] f;
      #1;
      b1 = ref_bus1();
      ref_alu(m_b, b1, ALU_Sel, r, f);
      case (Bus2_Sel)
         2'd0:    b2 = r;
         2'd1:    b2 = b1;
         2'd2:    b2 = from_memory;
         default: b2 = 8'h00;
      endcase
      if (!Reset) check_val({tag, "/to_memory"}, to_memory, b1);
      @(posedge Clk);
      if (Reset) begin
         m_pc = 0; m_a = 0; m_b = 0; m_ir = 0; m_mar = 0; m_ccr = 0;
      end else begin
         if (IR_Load)  m_ir  = b2;
         if (MAR_Load) m_mar = b2;
         if (A_Load)   m_a   = b2;
         if (B_Load)   m_b   = b2;
         if (CCR_Load) m_ccr = f;
         if (PC_Load)     m_pc = b2;
         else if (PC_Inc) m_pc = 8'((int'(m_pc) + 1) % 256);
      end
      #1;
      check_val({tag, "/address"}, address, m_mar);
      check_val({tag, "/IR"}, IR, m_ir);
      check_val({tag, "/CCR"}, 8'(CCR_Result), 8'(m_ccr));
   endtask

   task automatic peek(input string tag, input logic [1:0] sel, input logic [7:0] exp);
      idle();
      Bus1_Sel = sel;
      #1;
      check_val(tag, to_memory, exp);
   endtask

   task automatic load_reg(input bit is_a, input logic [7:0] v);
      set_in(0, 0, 0, 0, is_a, !is_a, 0, 3'd0, 2'd0, 2'd2, v);
      step(is_a ? "loadA" : "loadB");
   endtask

   initial begin
      idle();
      set_in(1, 1, 1, 1, 1, 1, 1, 3'd0, 2'd0, 2'd2, 8'hAA);
      Reset = 1;
      step("reset");
      check_val("reset/CCR0", 8'(CCR_Result), 8'h00);
      check_val("reset/addr0", address, 8'h00);
      peek("reset/PC", 2'd0, 8'h00);
      peek("reset/A", 2'd1, 8'h00);
      peek("reset/B", 2'd2, 8'h00);

      // fetch
      set_in(0, 1, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd1, 8'h00); step("fetch_mar");
      set_in(0, 0, 0, 1, 0, 0, 0, 3'd0, 2'd0, 2'd1, 8'h00); step("fetch_inc");
      set_in(1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd2, 8'h86); step("fetch_ir");
      check_val("fetch/IR86", IR, 8'h86);
      check_val("fetch/addr", address, 8'h00);
      peek("fetch/PC", 2'd0, 8'h01);

      // ADD overflow with read-before-write on A
      load_reg(1, 8'h7F);
      load_reg(0, 8'h01);
      set_in(0, 0, 0, 0, 1, 0, 1, 3'd0, 2'd1, 2'd0, 8'h00); step("add");
      check_val("add/CCR", 8'(CCR_Result), 8'h0A);
      peek("add/A", 2'd1, 8'h80);

      // SUB equal, then borrow
      load_reg(1, 8'h05);
      load_reg(0, 8'h05);
      set_in(0, 0, 0, 0, 0, 0, 1, 3'd1, 2'd1, 2'd0, 8'h00); step("sub_eq");
      check_val("sub_eq/CCR", 8'(CCR_Result), 8'h04);
      load_reg(1, 8'h06);
      set_in(0, 0, 0, 0, 0, 0, 1, 3'd1, 2'd1, 2'd0, 8'h00); step("sub_lt");
      check_val("sub_lt/CCR", 8'(CCR_Result), 8'h09);

      // PC wrap and load priority
      set_in(0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 2'd2, 8'hFF); step("pc_ff");
      set_in(0, 0, 0, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 8'h00); step("pc_wrap");
      peek("pc_wrap/PC", 2'd0, 8'h00);
      set_in(0, 0, 1, 1, 0, 0, 0, 3'd0, 2'd0, 2'd2, 8'h40); step("pc_prio");
      peek("pc_prio/PC", 2'd0, 8'h40);

      // reset discards an in-flight load
      set_in(0, 0, 0, 0, 1, 0, 0, 3'd0, 2'd0, 2'd2, 8'h55);
      Reset = 1;
      step("rst_load");
      peek("rst_load/A", 2'd1, 8'h00);
      set_in(0, 0, 0, 0, 1, 0, 0, 3'd0, 2'd0, 2'd2, 8'h55); step("load55");
      peek("load55/A", 2'd1, 8'h55);

      for (int i = 0; i < 300; i++) begin
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 8'($urandom));
         Reset = ($urandom_range(0, 31) == 0);
         step("rnd");
         peek("rnd/PC", 2'd0, m_pc);
         peek("rnd/A", 2'd1, m_a);
         peek("rnd/B", 2'd2, m_b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
